// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: instruction fields, opcodes,
// ALU command codes and the decoded-opcode record.
package alu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned IMM_W   = 18;

  // Instruction field bit positions
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RD_MSB  = 27;
  localparam int unsigned RD_LSB  = 23;
  localparam int unsigned RS1_MSB = 22;
  localparam int unsigned RS1_LSB = 18;
  localparam int unsigned RS2_MSB = 17;
  localparam int unsigned RS2_LSB = 13;
  localparam int unsigned IMM_MSB = 17;

  // Opcodes
  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_NOR  = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
  localparam logic [OP_W-1:0] OP_SLL  = 4'h6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'h7;
  localparam logic [OP_W-1:0] OP_SRL  = 4'h8;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h9;
  localparam logic [OP_W-1:0] OP_NOP  = 4'hA;

  // ALU command encodings
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_OR  = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_NOR = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_XOR = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_SLL = 4'b1000;
  localparam logic [CMD_W-1:0] CMD_SRA = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_SRL = 4'b1010;

  // Decoded opcode: nop forces both operands to zero
  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic             use_imm;
    logic             wb_en;
    logic             nop;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> {cmd, use_imm, wb_en, nop, illegal}.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  // Opcode lookup; unlisted opcodes are flagged illegal with a harmless NOP shape
  always_comb begin
    dec         = '0;
    dec.wb_en   = 1'b1;
    case (op)
      OP_ADD:  dec.cmd = CMD_ADD;
      OP_SUB:  dec.cmd = CMD_SUB;
      OP_AND:  dec.cmd = CMD_AND;
      OP_OR:   dec.cmd = CMD_OR;
      OP_NOR:  dec.cmd = CMD_NOR;
      OP_XOR:  dec.cmd = CMD_XOR;
      OP_SLL:  dec.cmd = CMD_SLL;
      OP_SRA:  dec.cmd = CMD_SRA;
      OP_SRL:  dec.cmd = CMD_SRL;
      OP_ADDI: begin
        dec.cmd     = CMD_ADD;
        dec.use_imm = 1'b1;
      end
      OP_NOP: begin
        dec.wb_en = 1'b0;
        dec.nop   = 1'b1;
      end
      default: begin
        dec.wb_en   = 1'b0;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU command interface. An output register
// plus one skid register keep in_ready driven straight from a flop.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN: drop illegal opcodes and report
// them on illegal_err/illegal_instr; otherwise they issue as NOP.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_AW-1:0]  rs1_addr,
  output logic [REG_AW-1:0]  rs2_addr,
  input  logic [DATA_W-1:0]  rs1_data,
  input  logic [DATA_W-1:0]  rs2_data,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [CMD_W-1:0]   ex_cmd,
  output logic [DATA_W-1:0]  ex_in1,
  output logic [DATA_W-1:0]  ex_in2,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_wb_en,
  output logic [CNT_W-1:0]   issued_cnt
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic               illegal_err,
  output logic [INSTR_W-1:0] illegal_instr
`endif
);

  localparam int unsigned BW = CMD_W + 2 * DATA_W + REG_AW + 1;

  dec_t              dec_c;
  logic              accept_c;
  logic              load_c;
  logic              zero_ops_c;
  logic [DATA_W-1:0] imm_c;
  logic [DATA_W-1:0] op1_c;
  logic [DATA_W-1:0] op2_c;
  logic [BW-1:0]     in_bundle_c;

  logic [BW-1:0]     out_q, out_d;
  logic [BW-1:0]     skid_q, skid_d;
  logic              out_v_q, out_v_d;
  logic              skid_v_q, skid_v_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic               illegal_err_q, illegal_err_d;
  logic [INSTR_W-1:0] illegal_instr_q, illegal_instr_d;
`endif

  assign rs1_addr = REG_AW'(instr[RS1_MSB:RS1_LSB]);
  assign rs2_addr = REG_AW'(instr[RS2_MSB:RS2_LSB]);

  alu_op_decode u_dec (
    .op  (instr[OP_MSB:OP_LSB]),
    .dec (dec_c)
  );

  // Operand selection and bundle assembly for the incoming instruction
  always_comb begin
    accept_c = in_valid && in_ready_q && !flush;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    zero_ops_c = dec_c.nop;
    load_c     = accept_c && !dec_c.illegal;
`else
    zero_ops_c = dec_c.nop || dec_c.illegal;
    load_c     = accept_c;
`endif
    imm_c = {{(DATA_W - IMM_W){instr[IMM_MSB]}}, instr[IMM_MSB:0]};
    op1_c = zero_ops_c ? '0 : rs1_data;
    op2_c = zero_ops_c ? '0 : (dec_c.use_imm ? imm_c : rs2_data);
    in_bundle_c = {dec_c.cmd, op1_c, op2_c, REG_AW'(instr[RD_MSB:RD_LSB]), dec_c.wb_en};
  end

  // Next-state for OUT/SKID, ready flop, counter and trap status
  always_comb begin
    out_d    = out_q;
    skid_d   = skid_q;
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;
    if (out_v_q && ex_ready && !flush) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || ex_ready) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = load_c;
        if (load_c) begin
          skid_d = in_bundle_c;
        end
      end else begin
        out_v_d = load_c;
        if (load_c) begin
          out_d = in_bundle_c;
        end
      end
    end else if (load_c) begin
      skid_d   = in_bundle_c;
      skid_v_d = 1'b1;
    end
    in_ready_d = !skid_v_d;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    illegal_err_d   = illegal_err_q;
    illegal_instr_d = illegal_instr_q;
    if (accept_c && dec_c.illegal && !illegal_err_q) begin
      illegal_err_d   = 1'b1;
      illegal_instr_d = instr;
    end
`endif
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_v_q    <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      illegal_err_q   <= 1'b0;
      illegal_instr_q <= '0;
`endif
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_v_q    <= out_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      illegal_err_q   <= illegal_err_d;
      illegal_instr_q <= illegal_instr_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign ex_valid   = out_v_q;
  assign {ex_cmd, ex_in1, ex_in2, ex_rd, ex_wb_en} = out_q;
  assign issued_cnt = cnt_q;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign illegal_err   = illegal_err_q;
  assign illegal_instr = illegal_instr_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage; builds with or without
// ALU_ISSUE_ILLEGAL_TRAP_EN.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_cmd;
  logic [31:0] ex_in1, ex_in2;
  logic [4:0]  ex_rd;
  logic        ex_wb_en;
  logic [31:0] issued_cnt;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic        illegal_err;
  logic [31:0] illegal_instr;
`endif

  int checks = 0;
  int passes = 0;
  logic [73:0] sb[$];
  logic [31:0] cnt_m = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_cmd(ex_cmd),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
    .issued_cnt(issued_cnt)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    , .illegal_err(illegal_err), .illegal_instr(illegal_instr)
`endif
  );

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                     input logic [4:0] r1, input logic [17:0] low);
    return {op, rd, r1, low};
  endfunction

  function automatic logic [73:0] model(input logic [31:0] w, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [3:0] cmd;
    logic [31:0] i1, i2;
    logic wb;
    i1 = a; i2 = b; wb = 1'b1; cmd = 4'b0000;
    case (w[31:28])
      4'h0: cmd = 4'b0000;
      4'h1: cmd = 4'b0010;
      4'h2: cmd = 4'b0100;
      4'h3: cmd = 4'b0101;
      4'h4: cmd = 4'b0110;
      4'h5: cmd = 4'b0111;
      4'h6: cmd = 4'b1000;
      4'h7: cmd = 4'b1001;
      4'h8: cmd = 4'b1010;
      4'h9: i2 = {{14{w[17]}}, w[17:0]};
      default: begin i1 = '0; i2 = '0; wb = 1'b0; end
    endcase
    return {cmd, i1, i2, w[27:23], wb};
  endfunction

  function automatic bit dropped(input logic [31:0] w);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    return w[31:28] > 4'hA;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: check handshake state and scoreboard, then advance to the next negedge
  task automatic step();
    logic [73:0] e;
    checks++;
    if (ex_valid !== (sb.size() != 0))
      $display("FAIL ex_valid: got %b want %b", ex_valid, sb.size() != 0);
    else passes++;
    checks++;
    if (in_ready !== (sb.size() < 2))
      $display("FAIL in_ready: got %b want %b", in_ready, sb.size() < 2);
    else passes++;
    if (ex_valid && ex_ready && !flush && sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({ex_cmd, ex_in1, ex_in2, ex_rd, ex_wb_en} !== e)
        $display("FAIL bundle: got %h want %h", {ex_cmd, ex_in1, ex_in2, ex_rd, ex_wb_en}, e);
      else passes++;
      cnt_m++;
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready && !dropped(instr)) sb.push_back(model(instr, rs1_data, rs2_data));
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (issued_cnt !== cnt_m)
      $display("FAIL issued_cnt: got %0d want %0d", issued_cnt, cnt_m);
    else passes++;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    bit acc = 0;
    in_valid = 1'b1; instr = w; rs1_data = a; rs2_data = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      step();
    end
    checks++;
    if (!acc) $display("FAIL send_timeout: got not accepted want accepted for %h", w);
    else passes++;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
    flush = 1'b0; ex_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ex_valid, ex_cmd, ex_in1, ex_in2, ex_rd, ex_wb_en} !== 75'd0)
      $display("FAIL reset_bundle: got %h want 0", {ex_valid, ex_cmd, ex_in1, ex_in2, ex_rd, ex_wb_en});
    else passes++;
    checks++;
    if (issued_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", issued_cnt);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passes++;
  endtask

  task automatic test_add();
    ex_ready = 1'b1;
    send(mk(4'h0, 5'd3, 5'd1, {5'd2, 13'd0}), 32'd7, 32'd5);
    checks++;
    if ({ex_valid, ex_cmd, ex_in1, ex_in2, ex_rd, ex_wb_en} !== {1'b1, 4'b0000, 32'd7, 32'd5, 5'd3, 1'b1})
      $display("FAIL add_direct: got %h want %h", {ex_valid, ex_cmd, ex_in1, ex_in2, ex_rd, ex_wb_en},
               {1'b1, 4'b0000, 32'd7, 32'd5, 5'd3, 1'b1});
    else passes++;
    idle(2);
  endtask

  task automatic test_ops();
    ex_ready = 1'b1;
    send(mk(4'h9, 5'd4, 5'd2, 18'h3FFFF), 32'd10, 32'h1234);
    checks++;
    if (ex_in2 !== 32'hFFFF_FFFF || ex_cmd !== 4'b0000)
      $display("FAIL addi_imm: got %h/%b want ffffffff/0000", ex_in2, ex_cmd);
    else passes++;
    send(mk(4'h7, 5'd5, 5'd1, 18'd0), 32'h8000_0000, 32'd3);
    checks++;
    if (ex_cmd !== 4'b1001) $display("FAIL sra_cmd: got %b want 1001", ex_cmd);
    else passes++;
    send(mk(4'h4, 5'd6, 5'd1, 18'd0), 32'hF0, 32'h0F);
    checks++;
    if (ex_cmd !== 4'b0110) $display("FAIL nor_cmd: got %b want 0110", ex_cmd);
    else passes++;
    for (int op = 0; op <= 10; op++)
      send(mk(4'(op), 5'(op + 1), 5'd7, 18'($urandom)), $urandom, $urandom);
    idle(2);
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b0;
    send(mk(4'h1, 5'd1, 5'd1, 18'd0), 32'd11, 32'd1);
    send(mk(4'h2, 5'd2, 5'd2, 18'd0), 32'd22, 32'd2);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready);
    else passes++;
    in_valid = 1'b1; instr = mk(4'h3, 5'd3, 5'd3, 18'd0); rs1_data = 32'd33; rs2_data = 32'd3;
    idle(3);
    ex_ready = 1'b1;
    send(instr, rs1_data, rs2_data);
    idle(3);
  endtask

  task automatic test_flush();
    logic [31:0] cnt_before;
    ex_ready = 1'b0;
    send(mk(4'h5, 5'd8, 5'd1, 18'd0), 32'hA, 32'hB);
    send(mk(4'h6, 5'd9, 5'd1, 18'd0), 32'hC, 32'hD);
    cnt_before = cnt_m;
    in_valid = 1'b1; instr = mk(4'h8, 5'd10, 5'd1, 18'd0); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_state: got valid=%b ready=%b want valid=0 ready=1", ex_valid, in_ready);
    else passes++;
    checks++;
    if (issued_cnt !== cnt_before) $display("FAIL flush_cnt: got %0d want %0d", issued_cnt, cnt_before);
    else passes++;
    ex_ready = 1'b1;
    idle(3);
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    ex_ready = 1'b1;
    w = mk(4'hC, 5'd12, 5'd3, 18'h155);
    send(w, 32'hDEAD, 32'hBEEF);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    checks++;
    if (ex_valid !== 1'b0) $display("FAIL illegal_issued: got %b want 0", ex_valid);
    else passes++;
    send(mk(4'hF, 5'd1, 5'd1, 18'd1), 32'd1, 32'd1);
    checks++;
    if (illegal_err !== 1'b1 || illegal_instr !== w)
      $display("FAIL illegal_trap: got err=%b word=%h want err=1 word=%h", illegal_err, illegal_instr, w);
    else passes++;
`else
    checks++;
    if ({ex_valid, ex_cmd, ex_in1, ex_in2, ex_wb_en} !== {1'b1, 4'b0000, 64'd0, 1'b0})
      $display("FAIL illegal_nop: got %h want %h", {ex_valid, ex_cmd, ex_in1, ex_in2, ex_wb_en},
               {1'b1, 4'b0000, 64'd0, 1'b0});
    else passes++;
`endif
    idle(2);
  endtask

  task automatic test_reset_mid();
    ex_ready = 1'b0;
    send(mk(4'h0, 5'd1, 5'd1, 18'd0), 32'd1, 32'd2);
    send(mk(4'h1, 5'd2, 5'd1, 18'd0), 32'd3, 32'd4);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || issued_cnt !== 32'd0)
      $display("FAIL midreset: got valid=%b cnt=%0d want 0/0", ex_valid, issued_cnt);
    else passes++;
    sb.delete();
    cnt_m = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", in_ready);
    else passes++;
    ex_ready = 1'b1;
    send(mk(4'h2, 5'd7, 5'd1, 18'd0), 32'hFF, 32'h0F);
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom);
      ex_ready = ($urandom_range(0, 3) != 0);
      instr = $urandom;
      rs1_data = $urandom;
      rs2_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    ex_ready = 1'b1;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
